crypto_dispatcher: RTL and testbench
====================================

# crypto_dispatcher

Request front-end for the 16-bit crypto core. Accepts (mode, key, data) jobs from the processor over a valid/ready port and buffers them in a small FIFO. Each job is sequenced onto the core: a core-reset pulse, then a held begin pulse, then a wait for completion. The core's data/key results are returned over a valid/ready response port. It sits directly upstream of the crypto core and owns its reset, begin, mode and input buses.

## Interface
- DEPTH, 4: request FIFO depth; power of two, ≥2.
- BGN_CYCLES, 10: cycles core_bgn is held high per job.
- TIMEOUT, 255: max WAIT cycles before an error response. Used only with CRYPTO_DISP_TIMEOUT_EN.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high when FIFO not full.
- req_mode  in  2  01 encrypt, 10 decrypt, other illegal.
- req_key  in  16  key word.
- req_data  in  16  data word.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  16  result data.
- rsp_key  out  16  result (final round) key.
- rsp_err  out  1  illegal mode or timeout.
- core_rst  out  1  active-low reset to core.
- core_bgn  out  1  core begin.
- core_mode  out  2  core cript_or_decript.
- core_key  out  16  core key_inbus.
- core_data  out  16  core data_inbus.
- core_done  in  1  core result valid this cycle; single-cycle pulse.
- core_data_in  in  16  core data_outbus.
- core_key_in  in  16  core key_outbus.
- busy  out  1  state≠IDLE or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO stores {mode,key,data}, 34 bits. Push on req_valid&&req_ready. req_ready = (fifo_count≠DEPTH), combinational. When full, a simultaneous pop does not open req_ready in the same cycle.
- IDLE: core_rst=1, core_bgn=0. If FIFO non-empty, pop head.
  - Legal mode: load core_mode/core_key/core_data registers, go to CLEAR.
  - Illegal mode: go to RESP with rsp_err=1, rsp_data=rsp_key=0000. The core is not touched.
- CLEAR: core_rst=0 for exactly 2 cycles, then START.
- START: core_rst=1, core_bgn=1 for BGN_CYCLES cycles, then WAIT.
- WAIT: core_bgn=0. On core_done, capture core_data_in/core_key_in into rsp_data/rsp_key, rsp_err=0, go to RESP.
- core_done is also honoured in START: bgn drops and the block goes to RESP. core_done is ignored in IDLE/CLEAR/RESP.
- RESP: rsp_valid=1; rsp_* stable until rsp_valid&&rsp_ready, then IDLE.
- core_mode/core_key/core_data hold the current job's values from pop until the next pop; they are never changed mid-job.
- FIFO pointers wrap modulo DEPTH; push and pop in the same cycle leave the count unchanged.

## Timing
- Reset (rst low, async):
  - State IDLE, FIFO empty, fifo_count=0.
  - rsp_valid=0, rsp_data=rsp_key=0000, rsp_err=0.
  - core_rst=0, core_bgn=0, core_mode=00, core_key=core_data=0000.
  - busy=0; req_ready=1.
- After release: core_rst goes 1 at the first clk edge.
- Reset mid-operation aborts the job and empties the FIFO; core_rst drops to 0 immediately.
- A push at edge t makes fifo_count valid after t. If IDLE, the pop happens at edge t+1 and CLEAR starts then.
- Job latency: pop edge → 2 CLEAR cycles → BGN_CYCLES START cycles → WAIT. done pulse in cycle n → rsp_valid high from edge n+1.
- Illegal mode: rsp_valid one cycle after pop.
- After a response transfer there is at least one IDLE cycle before the next pop.

## Configuration
- CRYPTO_DISP_TIMEOUT_EN defined:
  - A WAIT cycle counter (reset on WAIT entry) ends the job after TIMEOUT WAIT cycles without core_done.
  - Ending the job means RESP with rsp_err=1, rsp_data=rsp_key=0000, and core_rst pulsed low for 1 cycle.
- Not defined: no counter; WAIT lasts until core_done, indefinitely.

## Test plan
- Reset: assert rst mid-START with 2 jobs queued → core_rst=0 and core_bgn=0 at once, fifo_count=0, rsp_valid=0, busy=0; core_rst=1 one edge after release.
- Encrypt: push mode 01, key 1325, data 59B3. Core model pulses core_done 40 cycles after bgn rises, with data A5A5 and key 0F0F. Expect: core_rst low 2 cycles; core_bgn high 10 cycles; core_key=1325 and core_data=59B3 stable throughout; rsp_valid one cycle after done with A5A5/0F0F, rsp_err=0.
- Back-pressure: core never done; push 6 back-to-back → job 1 popped, fifo_count reaches 4, req_ready=0, 6th request held. After done plus a response transfer, fifo_count→3 and the 6th request is accepted.
- Illegal mode 11 with key a058, data 47e9 → rsp_err=1, rsp_data=0000, core_bgn never high, core_rst stays 1.
- Timeout (macro on, TIMEOUT=255): no done → rsp_valid after 255 WAIT cycles with rsp_err=1. Macro off: no response after 1000 cycles, busy=1.
- Response stall: rsp_ready low for 20 cycles → rsp_valid and rsp_data stay stable; the next queued job is not popped until the transfer completes.

Source files
------------

// File: rtl/crypto_dispatcher.sv
// Request FIFO and job sequencer in front of the 16-bit crypto core.
// Optional WAIT watchdog is enabled by defining CRYPTO_DISP_TIMEOUT_EN.
module crypto_dispatcher #(
  parameter int DEPTH      = 4,
  parameter int BGN_CYCLES = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_mode,
  input  logic [15:0]              req_key,
  input  logic [15:0]              req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_data,
  output logic [15:0]              rsp_key,
  output logic                     rsp_err,
  output logic                     core_rst,
  output logic                     core_bgn,
  output logic [1:0]               core_mode,
  output logic [15:0]              core_key,
  output logic [15:0]              core_data,
  input  logic                     core_done,
  input  logic [15:0]              core_data_in,
  input  logic [15:0]              core_key_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (BGN_CYCLES > TIMEOUT) ? BGN_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0]   FULL     = DEPTH[AW:0];
  localparam logic [CW-1:0] BGN_LAST = CW'(BGN_CYCLES - 1);
`ifdef CRYPTO_DISP_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
`endif

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] key;
    logic [15:0] data;
  } req_t;

  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} state_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  state_t        state;
  logic [CW-1:0] cnt;

  assign req_ready = (fifo_count != FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_mode, req_key, req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Core-side buses are only written on pop so they stay frozen for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      core_rst  <= 1'b0;
      core_bgn  <= 1'b0;
      core_mode <= '0;
      core_key  <= '0;
      core_data <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_key   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          core_rst <= 1'b1;
          core_bgn <= 1'b0;
          if (pop) begin
            if (head.mode == 2'b01 || head.mode == 2'b10) begin
              core_mode <= head.mode;
              core_key  <= head.key;
              core_data <= head.data;
              core_rst  <= 1'b0;
              cnt       <= '0;
              state     <= CLEAR;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_key   <= '0;
              state     <= RESP;
            end
          end
        end
        CLEAR: begin
          if (cnt == CW'(1)) begin
            core_rst <= 1'b1;
            core_bgn <= 1'b1;
            cnt      <= '0;
            state    <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          if (core_done) begin
            core_bgn  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= core_data_in;
            rsp_key   <= core_key_in;
            state     <= RESP;
          end else if (cnt == BGN_LAST) begin
            core_bgn <= 1'b0;
            cnt      <= '0;
            state    <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (core_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= core_data_in;
            rsp_key   <= core_key_in;
            state     <= RESP;
          end
`ifdef CRYPTO_DISP_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            // Hung core: report error and kick it with a one-cycle reset.
            core_rst  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_key   <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          core_rst <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_dispatcher.sv
// Directed bench for crypto_dispatcher; timeout scenario follows CRYPTO_DISP_TIMEOUT_EN.
module tb_crypto_dispatcher;
  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_key, req_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data, rsp_key;
  logic        rsp_err;
  logic        core_rst, core_bgn;
  logic [1:0]  core_mode;
  logic [15:0] core_key, core_data;
  logic        core_done;
  logic [15:0] core_data_in, core_key_in;
  logic        busy;
  logic [2:0]  fifo_count;

  int vec  = 0;
  int errs = 0;

  crypto_dispatcher #(.DEPTH(4), .BGN_CYCLES(10), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_key(rsp_key), .rsp_err(rsp_err),
    .core_rst(core_rst), .core_bgn(core_bgn), .core_mode(core_mode),
    .core_key(core_key), .core_data(core_data), .core_done(core_done),
    .core_data_in(core_data_in), .core_key_in(core_key_in),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; core_done = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push(input logic [1:0] m, input logic [15:0] k, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_mode = m; req_key = k; req_data = d;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) begin
      vec++; errs++; $display("FAIL push_wait req_ready got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vec++; if (core_rst !== 1'b0 || core_bgn !== 1'b0) begin errs++; $display("FAIL rst_core got rst=%b bgn=%b want 0/0", core_rst, core_bgn); end
    vec++; if (fifo_count !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL rst_fifo got cnt=%0d busy=%b rdy=%b want 0/0/1", fifo_count, busy, req_ready); end
    vec++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_key !== 16'h0 || rsp_err !== 1'b0) begin errs++; $display("FAIL rst_rsp got v=%b d=%h k=%h e=%b want 0/0000/0000/0", rsp_valid, rsp_data, rsp_key, rsp_err); end
    vec++; if (core_mode !== 2'b00 || core_key !== 16'h0 || core_data !== 16'h0) begin errs++; $display("FAIL rst_bus got m=%b k=%h d=%h want 00/0000/0000", core_mode, core_key, core_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    vec++; if (core_rst !== 1'b0) begin errs++; $display("FAIL rel_pre core_rst got %b want 0", core_rst); end
    tick();
    vec++; if (core_rst !== 1'b1) begin errs++; $display("FAIL rel_edge core_rst got %b want 1", core_rst); end
  endtask

  task automatic test_encrypt();
    int rl, bh, since;
    bit seen, bad, early, sent;
    push(2'b01, 16'h1325, 16'h59b3);
    vec++; if (fifo_count !== 3'd1 || core_rst !== 1'b1) begin errs++; $display("FAIL enc_push got cnt=%0d rst=%b want 1/1", fifo_count, core_rst); end
    tick();
    vec++; if (core_rst !== 1'b0 || fifo_count !== 3'd0 || core_key !== 16'h1325 || core_data !== 16'h59b3 || core_mode !== 2'b01)
      begin errs++; $display("FAIL enc_pop got rst=%b cnt=%0d k=%h d=%h m=%b want 0/0/1325/59b3/01", core_rst, fifo_count, core_key, core_data, core_mode); end
    rl = 1; bh = 0; since = 0; seen = 0; bad = 0; early = 0; sent = 0;
    for (int i = 0; i < 100 && !sent; i++) begin
      tick();
      if (rsp_valid) early = 1;
      if (!core_rst) rl++;
      if (core_bgn) bh++;
      if (core_bgn && !seen) begin seen = 1; since = 0; end
      else if (seen) since++;
      if (core_key !== 16'h1325 || core_data !== 16'h59b3 || core_mode !== 2'b01) bad = 1;
      if (seen && since == 40) begin
        core_done = 1'b1; core_data_in = 16'ha5a5; core_key_in = 16'h0f0f; sent = 1;
      end
    end
    tick();
    core_done = 1'b0;
    vec++; if (rl != 2) begin errs++; $display("FAIL enc_clear core_rst low cycles got %0d want 2", rl); end
    vec++; if (bh != 10) begin errs++; $display("FAIL enc_bgn core_bgn high cycles got %0d want 10", bh); end
    vec++; if (bad || early || !sent) begin errs++; $display("FAIL enc_hold got bad=%b early=%b sent=%b want 0/0/1", bad, early, sent); end
    vec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'ha5a5 || rsp_key !== 16'h0f0f || rsp_err !== 1'b0)
      begin errs++; $display("FAIL enc_rsp got v=%b d=%h k=%h e=%b want 1/a5a5/0f0f/0", rsp_valid, rsp_data, rsp_key, rsp_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL enc_xfer got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_illegal();
    bit bad;
    push(2'b11, 16'ha058, 16'h47e9);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL ill_pre rsp_valid got %b want 0", rsp_valid); end
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_key !== 16'h0)
      begin errs++; $display("FAIL ill_rsp got v=%b e=%b d=%h k=%h want 1/1/0000/0000", rsp_valid, rsp_err, rsp_data, rsp_key); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (core_bgn !== 1'b0 || core_rst !== 1'b1 || core_key !== 16'h1325 || core_data !== 16'h59b3) bad = 1;
      tick();
    end
    vec++; if (bad) begin errs++; $display("FAIL ill_core got core disturbed=%b want 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL ill_xfer rsp_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    bit bad;
    do_reset();
    push(2'b01, 16'h1111, 16'h2222);
    push(2'b10, 16'h3333, 16'h4444);
    for (int i = 0; i < 20; i++) tick();
    core_done = 1'b1; core_data_in = 16'hbeef; core_key_in = 16'hcafe;
    tick();
    core_done = 1'b0; core_data_in = 16'h0000; core_key_in = 16'h0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hbeef || rsp_key !== 16'hcafe || fifo_count !== 3'd1 || core_key !== 16'h1111) bad = 1;
      tick();
    end
    vec++; if (bad) begin errs++; $display("FAIL stall_hold got unstable=%b want 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec++; if (rsp_valid !== 1'b0 || fifo_count !== 3'd1) begin errs++; $display("FAIL stall_idle got v=%b cnt=%0d want 0/1", rsp_valid, fifo_count); end
    tick();
    vec++; if (fifo_count !== 3'd0 || core_key !== 16'h3333 || core_mode !== 2'b10)
      begin errs++; $display("FAIL stall_pop got cnt=%0d k=%h m=%b want 0/3333/10", fifo_count, core_key, core_mode); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] kk;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      kk = 16'h1000 + 16'(k);
      push(2'b01, kk, kk + 16'h1000);
    end
    req_valid = 1'b1; req_mode = 2'b01; req_key = 16'h1006; req_data = 16'h2006;
    for (int i = 0; i < 3; i++) tick();
    vec++; if (fifo_count !== 3'd4 || req_ready !== 1'b0) begin errs++; $display("FAIL bp_full got cnt=%0d rdy=%b want 4/0", fifo_count, req_ready); end
    vec++; if (core_key !== 16'h1001) begin errs++; $display("FAIL bp_job1 core_key got %h want 1001", core_key); end
    for (int i = 0; i < 15; i++) tick();
    core_done = 1'b1; core_data_in = 16'h0001; core_key_in = 16'h0002;
    tick();
    core_done = 1'b0;
    vec++; if (rsp_valid !== 1'b1 || fifo_count !== 3'd4 || req_ready !== 1'b0)
      begin errs++; $display("FAIL bp_rsp got v=%b cnt=%0d rdy=%b want 1/4/0", rsp_valid, fifo_count, req_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec++; if (fifo_count !== 3'd4 || req_ready !== 1'b0) begin errs++; $display("FAIL bp_idle got cnt=%0d rdy=%b want 4/0", fifo_count, req_ready); end
    tick();
    vec++; if (fifo_count !== 3'd3 || req_ready !== 1'b1 || core_key !== 16'h1002)
      begin errs++; $display("FAIL bp_pop got cnt=%0d rdy=%b k=%h want 3/1/1002", fifo_count, req_ready, core_key); end
    tick();
    req_valid = 1'b0;
    vec++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL bp_push6 fifo_count got %0d want 4", fifo_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push(2'b01, 16'h0aaa, 16'h0bbb);
    push(2'b10, 16'h0ccc, 16'h0ddd);
    push(2'b01, 16'h0eee, 16'h0fff);
    vec++; if (fifo_count !== 3'd2) begin errs++; $display("FAIL mid_queue fifo_count got %0d want 2", fifo_count); end
    n = 0;
    while (!core_bgn && n < 30) begin tick(); n++; end
    vec++; if (core_bgn !== 1'b1) begin errs++; $display("FAIL mid_start core_bgn got %b want 1", core_bgn); end
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    vec++; if (core_rst !== 1'b0 || core_bgn !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL mid_abort got rst=%b bgn=%b cnt=%0d v=%b busy=%b want 0/0/0/0/0", core_rst, core_bgn, fifo_count, rsp_valid, busy); end
    rst = 1'b1;
    tick();
    vec++; if (core_rst !== 1'b1 || core_bgn !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL mid_release got rst=%b bgn=%b busy=%b want 1/0/0", core_rst, core_bgn, busy); end
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    do_reset();
    push(2'b01, 16'h5555, 16'h6666);
`ifdef CRYPTO_DISP_TIMEOUT_EN
    n = 0;
    while (!core_bgn && n < 30) begin tick(); n++; end
    n = 0;
    while (core_bgn && n < 30) begin tick(); n++; end
    early = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (rsp_valid) early = 1;
    end
    vec++; if (early) begin errs++; $display("FAIL to_early rsp_valid got 1 want 0 before 255 WAIT cycles"); end
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || core_rst !== 1'b0)
      begin errs++; $display("FAIL to_rsp got v=%b e=%b d=%h rst=%b want 1/1/0000/0", rsp_valid, rsp_err, rsp_data, core_rst); end
    tick();
    vec++; if (core_rst !== 1'b1 || rsp_valid !== 1'b1) begin errs++; $display("FAIL to_kick got rst=%b v=%b want 1/1", core_rst, rsp_valid); end
`else
    n = 0;
    early = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rsp_valid) early = 1;
    end
    vec++; if (early || busy !== 1'b1) begin errs++; $display("FAIL no_to got v_seen=%b busy=%b want 0/1", early, busy); end
`endif
    do_reset();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_mode = 2'b00; req_key = 16'h0; req_data = 16'h0;
    rsp_ready = 1'b0; core_done = 1'b0; core_data_in = 16'h0; core_key_in = 16'h0;
    test_reset();
    test_encrypt();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
